uart_rx: RTL and testbench

//  UART receive stage, directly downstream of the baud generator. The baud

---
 rtl/uart_rx.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART 8N1 receiver, 16x oversampled from a baud square wave
//
// Samples the serial line at mid-bit using the rising edges of a 16x baud
// square wave as oversample ticks. It assembles a frame LSB-first and presents
// the byte with a one-clock done pulse.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : start + DBIT data + even parity bit + stop; parity_err reports mismatch
//   undefined : start + DBIT data + stop; parity_err is tied to 0
//
// Parameters:
//   DBIT     data bits per frame
//   SB_TICK  oversample ticks spent in the stop bit (16 = one stop bit)
//
// Ports:
//   clock         in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   baud          in   16x baud square wave; each rising edge is one tick
//   rx            in   serial line, idle high, asynchronous to clock
//   dout          out  last received byte, held until the next frame completes
//   rx_done_tick  out  one-clock pulse when dout/frame_err/parity_err update
//   frame_err     out  stop bit sampled low on the last frame
//   parity_err    out  parity mismatch on the last frame (0 without parity)
//   busy          out  receiver is not idle

module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            baud,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err,
    output logic            busy
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_s, w_s_nxt;
    logic [NW-1:0]   r_n, w_n_nxt;
    logic [DBIT-1:0] r_b, w_b_nxt;
    logic [DBIT-1:0] r_dout, w_dout_nxt;
    logic            r_done, w_done_nxt;
    logic            r_ferr, w_ferr_nxt;
    logic            r_rx_meta, r_rx_s;
    logic            r_baud_q;
    logic            w_tick;

`ifdef UART_RX_PARITY_EN
    logic            r_perr, w_perr_nxt;
    logic            r_perr_out, w_perr_out_nxt;
`endif

    // Input conditioning: rx is asynchronous, baud edge becomes a 1-clock tick
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_baud_q  <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_baud_q  <= baud;
        end
    end

    assign w_tick = baud & ~r_baud_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr     <= 1'b0;
            r_perr_out <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_b     <= w_b_nxt;
            r_dout  <= w_dout_nxt;
            r_done  <= w_done_nxt;
            r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_perr     <= w_perr_nxt;
            r_perr_out <= w_perr_out_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_b_nxt     = r_b;
        w_dout_nxt  = r_dout;
        w_done_nxt  = 1'b0;
        w_ferr_nxt  = r_ferr;
`ifdef UART_RX_PARITY_EN
        w_perr_nxt     = r_perr;
        w_perr_out_nxt = r_perr_out;
`endif
        case (r_state)
            // Start detection needs no tick so a start edge right after a
            // completed frame is caught on the very next clock.
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = ST_START;
                    w_s_nxt     = '0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_s == 4'd7) begin
                        // Mid start bit: still low means a real start,
                        // high means it was a glitch.
                        if (!r_rx_s) begin
                            w_state_nxt = ST_DATA;
                            w_s_nxt     = '0;
                            w_n_nxt     = '0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_s == 4'd15) begin
                        w_s_nxt = '0;
                        w_b_nxt = {r_rx_s, r_b[DBIT-1:1]};
                        if (r_n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = ST_PARITY;
`else
                            w_state_nxt = ST_STOP;
`endif
                        end else begin
                            w_n_nxt = r_n + 1'b1;
                        end
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    if (r_s == 4'd15) begin
                        // Even parity: data plus parity bit must hold an even count of ones
                        w_perr_nxt  = ^{r_b, r_rx_s};
                        w_state_nxt = ST_STOP;
                        w_s_nxt     = '0;
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    if (r_s == 4'(SB_TICK - 1)) begin
                        w_dout_nxt  = r_b;
                        w_ferr_nxt  = ~r_rx_s;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        w_perr_out_nxt = r_perr;
`endif
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_ferr;
    assign busy         = (r_state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err   = r_perr_out;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level reference model
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int BAUD_P  = 6;            // clocks per baud square-wave period
    localparam int BIT_CLK = 16 * BAUD_P;  // clocks per serial bit

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } frame_t;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud    = 1'b0;
    logic       rx      = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    frame_t     exp_q[$];
    frame_t     got_q[$];
    bit         perr_seen = 1'b0;
    logic       prev_done = 1'b0;
    logic [7:0] prev_dout = 8'h00;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .baud         (baud),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .parity_err   (parity_err),
        .busy         (busy)
    );

    always #10 clock = ~clock;
    always #(10 * BAUD_P) baud = ~baud;

    // Collects every done pulse; flags wide pulses and output fields moving without a pulse
    always @(negedge clock) begin
        if (reset_n) begin
            if (rx_done_tick) begin
                got_q.push_back('{data: dout, ferr: frame_err, perr: parity_err});
                n_checks++;
                if (prev_done) begin
                    n_fail++;
                    $display("FAIL done_width: got 2 consecutive high clocks, expected 1");
                end
            end else if (dout !== prev_dout) begin
                n_fail++;
                $display("FAIL dout_hold: got %h, expected %h (no done pulse)", dout, prev_dout);
            end
            if (parity_err !== 1'b0) perr_seen = 1'b1;
        end
        prev_done = rx_done_tick;
        prev_dout = dout;
    end

    task automatic send_bit(input logic v, input int ticks);
        rx = v;
        repeat (ticks * BAUD_P) @(negedge clock);
    endtask

    // Frame-level model: the receiver must return exactly the byte sent, frame error
    // iff the stop bit was low, parity error iff data+parity has an odd count of ones.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_flip);
        logic pbit;
        logic perr_exp;
        pbit = (($countones(d) % 2) == 1) ^ par_flip;
`ifdef UART_RX_PARITY_EN
        perr_exp = (($countones(d) + int'(pbit)) % 2) != 0;
`else
        perr_exp = 1'b0;
`endif
        exp_q.push_back('{data: d, ferr: ~stop_ok, perr: perr_exp});
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
        send_bit(pbit, 16);
`endif
        if (stop_ok) begin
            send_bit(1'b1, 16);
        end else begin
            // Low across the mid-bit sample, then released so no phantom start follows
            send_bit(1'b0, 10);
            send_bit(1'b1, 6);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 4 * BIT_CLK && got_q.size() < exp_q.size(); k++) @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h, expected 00", dout); end
        n_checks++; if (rx_done_tick !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", rx_done_tick); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b, expected 0", frame_err); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b, expected 0", parity_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        reset_n = 1'b1;
        repeat (BIT_CLK) @(negedge clock);
    endtask

    task automatic test_single_frame();
        logic busy_mid;
        busy_mid = 1'b0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                repeat (3 * BIT_CLK) @(negedge clock);
                busy_mid = busy;
            end
        join
        drain();
        n_checks++; if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL t1_busy_mid: got %b, expected 1", busy_mid); end
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL t1_count: got %0d, expected 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_checks++; if (got_q[0].data !== 8'hA5) begin n_fail++; $display("FAIL t1_data: got %h, expected a5", got_q[0].data); end
            n_checks++; if (got_q[0].ferr !== 1'b0) begin n_fail++; $display("FAIL t1_ferr: got %b, expected 0", got_q[0].ferr); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_after: got %b, expected 0", busy); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_glitch();
        send_bit(1'b0, 3);
        send_bit(1'b1, 32);
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL t2_count: got %0d, expected 0", got_q.size()); end
        n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL t2_dout: got %h, expected a5", dout); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t2_busy: got %b, expected 0", busy); end
        got_q.delete();
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b0);
        send_bit(1'b1, 16);
        send_frame(8'h81, 1'b1, 1'b0);
        drain();
        n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL t3_count: got %0d, expected 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL t3_frame%0d: got data=%h ferr=%b, expected data=%h ferr=%b",
                         i, got_q[i].data, got_q[i].ferr, exp_q[i].data, exp_q[i].ferr);
            end
        end
        n_checks++; if (dout !== 8'h81) begin n_fail++; $display("FAIL t3_dout: got %h, expected 81", dout); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL t3_ferr_final: got %b, expected 0", frame_err); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
        send_bit(1'b1, 8);
        #3 reset_n = 1'b0;
        #1;
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL t4_dout: got %h, expected 00", dout); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t4_busy: got %b, expected 0", busy); end
        n_checks++; if (rx_done_tick !== 1'b0) begin n_fail++; $display("FAIL t4_done: got %b, expected 0", rx_done_tick); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL t4_ferr: got %b, expected 0", frame_err); end
        rx = 1'b1;
        repeat (20) @(negedge clock);
        reset_n = 1'b1;
        repeat (BIT_CLK) @(negedge clock);
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL t4_no_pulse: got %0d, expected 0", got_q.size()); end
        send_frame(8'h55, 1'b1, 1'b0);
        drain();
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL t4_count: got %0d, expected 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_checks++; if (got_q[0].data !== 8'h55) begin n_fail++; $display("FAIL t4_data: got %h, expected 55", got_q[0].data); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h5A;
        for (int i = 0; i < 3; i++) send_frame(vals[i], 1'b1, 1'b0);
        drain();
        n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL t5_count: got %0d, expected 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i].data !== vals[i] || got_q[i].ferr !== 1'b0) begin
                n_fail++;
                $display("FAIL t5_frame%0d: got data=%h ferr=%b, expected data=%h ferr=0",
                         i, got_q[i].data, got_q[i].ferr, vals[i]);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b1);
        drain();
        n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL t6_count: got %0d, expected 2", got_q.size()); end
        if (got_q.size() >= 2) begin
            n_checks++; if (got_q[0].perr !== 1'b0) begin n_fail++; $display("FAIL t6_perr_good: got %b, expected 0", got_q[0].perr); end
            n_checks++; if (got_q[1].perr !== 1'b1) begin n_fail++; $display("FAIL t6_perr_bad: got %b, expected 1", got_q[1].perr); end
            n_checks++; if (got_q[1].data !== 8'h3C) begin n_fail++; $display("FAIL t6_data: got %h, expected 3c", got_q[1].data); end
        end
`else
        send_frame(8'h3C, 1'b1, 1'b1);
        drain();
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL t6_count: got %0d, expected 1", got_q.size()); end
        n_checks++; if (perr_seen !== 1'b0) begin n_fail++; $display("FAIL t6_perr_const: got %b, expected 0", perr_seen); end
`endif
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       stop_ok;
        logic       flip;
        int         gap;
        for (int f = 0; f < 10; f++) begin
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            flip    = 1'($urandom_range(0, 1));
            gap     = stop_ok ? int'($urandom_range(0, 1)) : 1;
            send_frame(d, stop_ok, flip);
            if (gap > 0) send_bit(1'b1, 16 * gap);
        end
        drain();
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rnd_frame%0d: got data=%h ferr=%b perr=%b, expected data=%h ferr=%b perr=%b",
                         i, got_q[i].data, got_q[i].ferr, got_q[i].perr,
                         exp_q[i].data, exp_q[i].ferr, exp_q[i].perr);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_back_to_back();
        test_parity();
        test_random();
`ifndef UART_RX_PARITY_EN
        n_checks++; if (perr_seen !== 1'b0) begin n_fail++; $display("FAIL perr_const_all: got %b, expected 0", perr_seen); end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
